imem_loader: RTL and testbench

Boot-time writer for the CPU's word-addressed instruction memory. It accepts a byte stream from the UART receiver, frames it as a length-prefixed, checksummed program image, and writes each assembled 32-bit word into instruction RAM at sequential word addresses. It holds the CPU for the whole load, then releases it with a one-cycle completion pulse so the core restarts at address 0 (the Reset vector).

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the word-addressed instruction RAM.
// Receives a framed program image byte by byte from the UART receiver and
// writes each 32-bit word to instruction RAM at sequential word addresses.
// The CPU is held for the whole load. A one-cycle done pulse marks a load
// that ended with a good checksum.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), N*4 data bytes
// (each word MSB first), then one checksum byte (XOR of the data bytes).
//
// Handshake: rx_valid is a one-cycle strobe with no ready/backpressure.
// A byte is taken on every rising edge where rx_valid=1 and the FSM is in
// a receive state (LEN_HI, LEN_LO, DATA, CHECK). Elsewhere it is dropped.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   load_en    start request, sampled only in IDLE
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   cpu_hold   high in every state except IDLE
//   mem_we     one-cycle instruction-RAM write strobe
//   mem_addr   byte address of the write, {zeros, word_idx, 2'b00}
//   mem_wdata  assembled instruction word
//   done       one-cycle pulse on a successful load
//   error      sticky error flag, cleared by the next accepted load_en
//   word_count words written in the current or last load
//   state_dbg  current FSM state, for debug and assertion binding
module imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  cpu_hold,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [2:0]            state_dbg
);

  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  // Only the three earlier bytes of a word need storing; the fourth is
  // taken straight from rx_data when the word is written.
  logic [23:0]             shift_q, shift_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic [7:0]              xor_q, xor_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    error_q, error_d;
  logic                    receiving;
  logic [16:0]             n_rx;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    xor_d        = xor_q;
    tmo_d        = tmo_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    error_d      = error_q;
    n_rx         = {1'b0, len_q[15:8], rx_data};

    receiving = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                (state_q == S_DATA)   || (state_q == S_CHECK);

    // Idle-gap counter: cleared by every accepted byte.
    if (receiving) begin
      tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d      = S_LEN_HI;
          error_d      = 1'b0;
          word_count_d = '0;
          word_idx_d   = '0;
          byte_cnt_d   = '0;
          xor_d        = '0;
          tmo_d        = '0;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          if (n_rx > MAX_N)       state_d = S_ERR;
          else if (n_rx == 17'd0) state_d = S_CHECK;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          shift_d    = {shift_q[15:0], rx_data};
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d         = 1'b1;
            waddr_d      = word_idx_q;
            wdata_d      = {shift_q, rx_data};
            word_idx_d   = word_idx_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
            if (17'(word_count_q) + 17'd1 == {1'b0, len_q}) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A full timeout window with no byte aborts the load.
    if (receiving && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_ERR;
    end

    if (state_d == S_ERR) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      word_count_q <= '0;
      xor_q        <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      xor_q        <= xor_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      error_q      <= error_d;
    end
  end

  assign cpu_hold   = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign mem_we     = we_q;
  assign mem_addr   = 32'({waddr_q, 2'b00});
  assign mem_wdata  = wdata_q;
  assign error      = error_q;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cpu_hold;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        error;
  logic [8:0]  word_count;
  logic [2:0]  state_dbg;

  int n_chk = 0;
  int n_err = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  imem_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_en    (load_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cpu_hold   (cpu_hold),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      check_val("we_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check_val("write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      check_val("hold_at_done", 64'(cpu_hold), 64'd1);
    end
  end

  // driver tasks (all called on a falling edge)
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_load();
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check_val("hold_rise", 64'(cpu_hold), 64'd1);
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [7:0]  x;
    logic [15:0] len;
    logic [7:0]  b;
    x   = 8'h00;
    len = 16'(n);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(i * 4), words[i]});
      for (int k = 0; k < 4; k++) begin
        b = words[i][31 - 8 * k -: 8];
        x = x ^ b;
        send_byte(b);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    send_byte(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (cpu_hold && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_val("idle_reached", 64'(cpu_hold), 64'd0);
  endtask

  initial begin
    int b_we;
    int b_done;
    int c;
    rst_n    = 1'b0;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {cpu_hold, mem_we, done, error, state_dbg}, 64'd0);
    check_val("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
    check_val("rst_wcount", 64'(word_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // two-word load from the reference frame
    words = '{32'h08000003, 32'h201C0000};
    b_we = we_cnt; b_done = done_cnt;
    start_load();
    send_frame(2, 1'b0, 1'b0);
    check_val("hold_in_done", 64'(cpu_hold), 64'd1);
    wait_idle();
    check_val("t1_we", 64'(we_cnt - b_we), 64'd2);
    check_val("t1_done", 64'(done_cnt - b_done), 64'd1);
    check_val("t1_wcount", 64'(word_count), 64'd2);
    check_val("t1_error", 64'(error), 64'd0);

    // bad checksum (0x36)
    b_we = we_cnt; b_done = done_cnt;
    start_load();
    send_frame(2, 1'b1, 1'b0);
    wait_idle();
    check_val("t2_we", 64'(we_cnt - b_we), 64'd2);
    check_val("t2_done", 64'(done_cnt - b_done), 64'd0);
    check_val("t2_error", 64'(error), 64'd1);

    // oversize length 257
    b_we = we_cnt;
    start_load();
    check_val("t3_err_cleared", 64'(error), 64'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    check_val("t3_err_now", {cpu_hold, error}, 64'b11);
    @(negedge clk);
    check_val("t3_hold_fall", 64'(cpu_hold), 64'd0);
    check_val("t3_we", 64'(we_cnt - b_we), 64'd0);

    // N = 0
    words.delete();
    b_we = we_cnt; b_done = done_cnt;
    start_load();
    send_frame(0, 1'b0, 1'b0);
    wait_idle();
    check_val("t4_done", 64'(done_cnt - b_done), 64'd1);
    check_val("t4_we", 64'(we_cnt - b_we), 64'd0);
    check_val("t4_wcount", 64'(word_count), 64'd0);
    check_val("t4_error", 64'(error), 64'd0);

    // full 256-word load, random data and random gaps
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    b_we = we_cnt; b_done = done_cnt;
    start_load();
    send_frame(256, 1'b0, 1'b1);
    wait_idle();
    check_val("t5_we", 64'(we_cnt - b_we), 64'd256);
    check_val("t5_done", 64'(done_cnt - b_done), 64'd1);
    check_val("t5_wcount", 64'(word_count), 64'd256);
    check_val("t5_error", 64'(error), 64'd0);

    // timeout: 00 01 08 then silence
    b_we = we_cnt;
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h08);
    c = 0;
    while (!error && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_val("t6_tmo_cycles", 64'(c), 64'd16);
    check_val("t6_we", 64'(we_cnt - b_we), 64'd0);
    wait_idle();

    // reset in the write cycle of the first word
    words = '{32'hA1B2C3D4, 32'h55667788};
    exp_q.push_back({32'h0, 32'hA1B2C3D4});
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    #1 rst_n = 1'b0;
    #1;
    check_val("t7_rst_outs", {cpu_hold, mem_we, done, error, state_dbg}, 64'd0);
    check_val("t7_rst_data", {mem_addr, mem_wdata}, 64'd0);
    check_val("t7_rst_wcount", 64'(word_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b_we = we_cnt; b_done = done_cnt;
    start_load();
    send_frame(2, 1'b0, 1'b1);
    wait_idle();
    check_val("t7_we", 64'(we_cnt - b_we), 64'd2);
    check_val("t7_done", 64'(done_cnt - b_done), 64'd1);
    check_val("t7_wcount", 64'(word_count), 64'd2);

    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
